// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding and counter sizing for the reset sequencer
// Contents: reset_seq_state_t state enum, cnt_width() timer width helper.
package reset_seq_pkg;

   typedef enum logic [2:0] {ASSERT, SEQ, PULSE, DONE, DEASSERT_REV} reset_seq_state_t;

   // Width for a down-counter that must hold max(gap, pulse)-1; never below 1 bit.
   function automatic int cnt_width(input int gap, input int pulse);
      int m;
      m = (gap > pulse) ? gap : pulse;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: control/status bundle between the reset sequencer and its register block
// Signals: hold, sw_rst_req (to sequencer); resn_out[NUM_OUT-1:0], busy, seq_done (from sequencer).
// Modports: master = sequencer side, slave = register block / consumer side.
interface reset_sequencer_if #(
   parameter int NUM_OUT = 4
) ();

   logic               hold;
   logic               sw_rst_req;
   logic [NUM_OUT-1:0] resn_out;
   logic               busy;
   logic               seq_done;

   modport master (input hold, sw_rst_req, output resn_out, busy, seq_done);
   modport slave  (output hold, sw_rst_req, input resn_out, busy, seq_done);

endinterface

// File: rtl/reset_seq_timer.sv
// reset_seq_timer: loadable down-counter shared by the sequencer's timed waits
// Ports: clk, resn (async active-low, restores RST_VAL), load/load_val (reload),
//        en (decrement), zero (count is zero).
module reset_seq_timer #(
   parameter int           W       = 4,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         resn,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge resn)
      if (!resn) cnt <= RST_VAL;
      else if (load) cnt <= load_val;
      else if (en) cnt <= cnt - 1'b1;

   assign zero = (cnt == '0);

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_OUT reset domains in index order, GAP_CYCLES apart
// Ports: clk, resn (synchronized reset, async assert, active-low),
//        bus (reset_sequencer_if.master: hold, sw_rst_req in; resn_out, busy, seq_done out).
// Optional: RESET_SEQ_REVERSE_ASSERT_EN re-asserts domains highest-first on a software request.
module reset_sequencer import reset_seq_pkg::*; #(
   parameter int NUM_OUT    = 4,
   parameter int GAP_CYCLES = 16,
   parameter int SW_PULSE   = 8
) (
   input  logic                clk,
   input  logic                resn,
   reset_sequencer_if.master   bus
);

   localparam int             CW     = cnt_width(GAP_CYCLES, SW_PULSE);
   localparam int             IW     = $clog2(NUM_OUT);
   localparam logic [CW-1:0]  GAP_LD = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0]  SW_LD  = CW'(SW_PULSE - 1);
   localparam logic [IW-1:0]  LAST   = IW'(NUM_OUT - 1);

   reset_seq_state_t   state, state_n;
   logic [IW-1:0]      idx, idx_n;
   logic [NUM_OUT-1:0] out_q, out_n;
   logic               load, en, zero;
   logic [CW-1:0]      load_val;

   reset_seq_timer #(.W(CW), .RST_VAL(GAP_LD)) u_timer (
      .clk      (clk),
      .resn     (resn),
      .load     (load),
      .en       (en),
      .load_val (load_val),
      .zero     (zero)
   );

   always_ff @(posedge clk or negedge resn)
      if (!resn) begin
         state <= ASSERT;
         idx   <= '0;
         out_q <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         out_q <= out_n;
      end

   // The counter is never allowed to wrap: every wait reloads it on the zero cycle.
   always_comb begin
      state_n  = state;
      idx_n    = idx;
      out_n    = out_q;
      load     = 1'b0;
      en       = 1'b0;
      load_val = GAP_LD;
      case (state)
         ASSERT: begin
            if (bus.hold) load = 1'b1;
            else begin
               state_n = SEQ;
               en      = 1'b1;
            end
         end
         SEQ: begin
            if (zero) begin
               out_n[idx] = 1'b1;
               load       = 1'b1;
               idx_n      = (idx == LAST) ? '0 : idx + 1'b1;
               state_n    = (idx == LAST) ? DONE : SEQ;
            end else en = 1'b1;
         end
         PULSE: begin
            if (zero) begin
               state_n = SEQ;
               idx_n   = '0;
               load    = 1'b1;
            end else en = 1'b1;
         end
         DONE: begin
            if (bus.sw_rst_req) begin
               load = 1'b1;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
               out_n[LAST] = 1'b0;
               idx_n       = IW'(NUM_OUT - 2);
               state_n     = DEASSERT_REV;
`else
               out_n    = '0;
               load_val = SW_LD;
               state_n  = PULSE;
`endif
            end
         end
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
         DEASSERT_REV: begin
            if (zero) begin
               out_n[idx] = 1'b0;
               load       = 1'b1;
               load_val   = (idx == '0) ? SW_LD : GAP_LD;
               idx_n      = (idx == '0) ? '0 : idx - 1'b1;
               state_n    = (idx == '0) ? PULSE : DEASSERT_REV;
            end else en = 1'b1;
         end
`endif
         default: state_n = ASSERT;
      endcase
   end

   assign bus.resn_out = out_q;
   assign bus.busy     = (state != DONE);
   assign bus.seq_done = (state == DONE);

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench for reset_sequencer (NUM_OUT=4, GAP_CYCLES=16, SW_PULSE=8)
// Honours RESET_SEQ_REVERSE_ASSERT_EN for the software-reset expectations.
module tb_reset_sequencer;

   localparam int N   = 4;
   localparam int GAP = 16;
   localparam int SWP = 8;

   typedef struct {
      int           cyc;
      logic [N+1:0] v;
   } exp_t;

   logic clk  = 1'b0;
   logic resn = 1'b0;
   int   cyc  = 0;
   int   n_chk  = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;
   exp_t sb[$];
   exp_t cur;

   reset_sequencer_if #(.NUM_OUT(N)) bus ();

   reset_sequencer #(.NUM_OUT(N), .GAP_CYCLES(GAP), .SW_PULSE(SWP)) dut (
      .clk  (clk),
      .resn (resn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Edge numbering: edge 1 is the first rising edge that samples resn=1.
   always @(posedge clk) cyc <= resn ? cyc + 1 : 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input int c, input logic [N-1:0] o, input logic b, input logic d);
      exp_t e;
      e.cyc = c;
      e.v   = {o, b, d};
      sb.push_back(e);
   endtask

   // Release k lands at base + GAP*(k+1); the final release also flips busy/seq_done.
   task automatic push_seq(input int base);
      for (int k = 0; k < N; k++)
         push(base + GAP * (k + 1), N'((1 << (k + 1)) - 1), k != N - 1, k == N - 1);
   endtask

   task automatic run_to(input int n);
      int g = 0;
      while (cyc < n && g < 5000) begin
         @(posedge clk);
         #3;
         g++;
      end
      check($sformatf("reach%0d", n), cyc, n);
   endtask

   task automatic start(input logic h);
      bus.hold = h;
      cur.cyc  = 0;
      cur.v    = {N'(0), 1'b1, 1'b0};
      mon_en   = 1'b1;
      resn     = 1'b1;
   endtask

   task automatic abort();
      mon_en = 1'b0;
      resn   = 1'b0;
      #1;
      check("async_rst", {bus.resn_out, bus.busy, bus.seq_done}, {N'(0), 1'b1, 1'b0});
      sb.delete();
      repeat (3) @(posedge clk);
      #3;
   endtask

   always @(negedge clk)
      if (mon_en) begin
         if (sb.size() > 0 && sb[0].cyc == cyc) cur = sb.pop_front();
         check($sformatf("edge%0d", cyc), {bus.resn_out, bus.busy, bus.seq_done}, cur.v);
      end

   initial begin
      int t;
      bus.hold       = 1'b0;
      bus.sw_rst_req = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      check("rst_out", bus.resn_out, 0);
      check("rst_busy", bus.busy, 1);
      check("rst_done", bus.seq_done, 0);
      // plain release, with a request during SEQ that must be ignored
      push_seq(0);
      start(1'b0);
      run_to(19);
      bus.sw_rst_req = 1'b1;
      run_to(20);
      bus.sw_rst_req = 1'b0;
      run_to(70);
      // software reset sampled at edge t in DONE
      t = cyc + 1;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
      for (int k = N - 1; k >= 0; k--)
         push(t + (N - 1 - k) * GAP, N'((1 << k) - 1), 1'b1, 1'b0);
      push_seq(t + (N - 1) * GAP + SWP);
`else
      push(t, N'(0), 1'b1, 1'b0);
      push_seq(t + SWP);
`endif
      bus.sw_rst_req = 1'b1;
      run_to(t);
      bus.sw_rst_req = 1'b0;
      run_to(t + 130);
      // reset dropped mid-sequence, then a full rerun
      abort();
      push_seq(0);
      start(1'b0);
      run_to(33);
      abort();
      push_seq(0);
      start(1'b0);
      run_to(70);
      // hold keeps everything in reset until released after edge 40
      abort();
      start(1'b1);
      run_to(40);
      bus.hold = 1'b0;
      push_seq(40);
      run_to(110);
      check("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
